// File: rtl/matmul_buf_ctrl_if.sv
// Host port, run control and systolic-core port of the matmul buffer controller.
// The controller takes the slave side, the host/core environment the master side.
interface matmul_buf_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int SIZE   = 16,
  parameter int AWIDTH = 7
);
  localparam int RW = SIZE * DWIDTH;

  logic              host_we_a;
  logic              host_we_b;
  logic              host_re_c;
  logic [AWIDTH-1:0] host_addr;
  logic [RW-1:0]     host_wdata;
  logic [RW-1:0]     host_rdata;
  logic              host_rvalid;
  logic              host_err;

  logic              start;
  logic [AWIDTH-1:0] a_base;
  logic [AWIDTH-1:0] b_base;
  logic [AWIDTH-1:0] c_base;
  logic              busy;
  logic              done;
  logic              c_ovf;

  logic              core_start;
  logic [RW-1:0]     core_a_data;
  logic [RW-1:0]     core_b_data;
  logic              core_feed_valid;
  logic [RW-1:0]     core_c_data;
  logic              core_c_valid;
  logic              core_done;

  modport slave (
    input  host_we_a, host_we_b, host_re_c, host_addr, host_wdata,
    input  start, a_base, b_base, c_base,
    input  core_c_data, core_c_valid, core_done,
    output host_rdata, host_rvalid, host_err,
    output busy, done, c_ovf,
    output core_start, core_a_data, core_b_data, core_feed_valid
  );

  modport master (
    output host_we_a, host_we_b, host_re_c, host_addr, host_wdata,
    output start, a_base, b_base, c_base,
    output core_c_data, core_c_valid, core_done,
    input  host_rdata, host_rvalid, host_err,
    input  busy, done, c_ovf,
    input  core_start, core_a_data, core_b_data, core_feed_valid
  );
endinterface

// File: rtl/matmul_buf_ctrl.sv
// Operand/result buffers plus run sequencer in front of a systolic matrix-multiply core.
// Streams SIZE rows of A and B into the core and captures SIZE result rows into C.
module matmul_buf_ctrl #(
  parameter int DWIDTH = 16,
  parameter int SIZE   = 16,
  parameter int AWIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  matmul_buf_ctrl_if.slave bus
);
  localparam int RW    = SIZE * DWIDTH;
  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] FULL = CW'(SIZE);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t            state;
  logic [AWIDTH-1:0] base_a, base_b, base_c;
  logic [CW-1:0]     fcnt, ccnt;
  logic              done_seen;

  logic [RW-1:0] mem_a [DEPTH];
  logic [RW-1:0] mem_b [DEPTH];
  logic [RW-1:0] mem_c [DEPTH];

  logic              idle, we_a, we_b, re_c, capture, overflow;
  logic              any_req, multi_req;
  logic [AWIDTH-1:0] rd_addr_a, rd_addr_b, addr_c;

  assign idle      = (state == IDLE);
  assign we_a      = idle && bus.host_we_a;
  assign we_b      = idle && bus.host_we_b && !bus.host_we_a;
  assign re_c      = idle && bus.host_re_c && !bus.host_we_a && !bus.host_we_b;
  assign any_req   = bus.host_we_a | bus.host_we_b | bus.host_re_c;
  assign multi_req = (bus.host_we_a & bus.host_we_b) | (bus.host_we_a & bus.host_re_c) |
                     (bus.host_we_b & bus.host_re_c);
  assign capture   = !idle && bus.core_c_valid && (ccnt < FULL);
  assign overflow  = !idle && bus.core_c_valid && (ccnt == FULL);

  // Base+offset truncates to AWIDTH, so runs wrap past the top row silently.
  assign rd_addr_a = base_a + AWIDTH'(fcnt);
  assign rd_addr_b = base_b + AWIDTH'(fcnt);
  assign addr_c    = idle ? bus.host_addr : base_c + AWIDTH'(ccnt);

  always_ff @(posedge clk) begin
    if (we_a) mem_a[bus.host_addr] <= bus.host_wdata;
    if (we_b) mem_b[bus.host_addr] <= bus.host_wdata;
    if (capture) mem_c[addr_c] <= bus.core_c_data;
  end

  // Read registers carry the async reset so every output is zero while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.core_a_data <= '0;
      bus.core_b_data <= '0;
      bus.host_rdata  <= '0;
    end else begin
      if (state == FEED) begin
        bus.core_a_data <= mem_a[rd_addr_a];
        bus.core_b_data <= mem_b[rd_addr_b];
      end
      if (re_c) bus.host_rdata <= mem_c[addr_c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      base_a              <= '0;
      base_b              <= '0;
      base_c              <= '0;
      fcnt                <= '0;
      ccnt                <= '0;
      done_seen           <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.c_ovf           <= 1'b0;
      bus.core_start      <= 1'b0;
      bus.core_feed_valid <= 1'b0;
      bus.host_err        <= 1'b0;
      bus.host_rvalid     <= 1'b0;
    end else begin
      bus.core_start      <= 1'b0;
      bus.done            <= 1'b0;
      bus.core_feed_valid <= (state == FEED);
      bus.host_rvalid     <= re_c;
      bus.host_err        <= idle ? multi_req : any_req;
      if (capture) ccnt <= ccnt + CW'(1);
      if (overflow) bus.c_ovf <= 1'b1;
      if (!idle && bus.core_done) done_seen <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            base_a         <= bus.a_base;
            base_b         <= bus.b_base;
            base_c         <= bus.c_base;
            fcnt           <= '0;
            ccnt           <= '0;
            done_seen      <= 1'b0;
            bus.c_ovf      <= 1'b0;
            bus.core_start <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= FEED;
          end
        end
        FEED: begin
          fcnt <= fcnt + CW'(1);
          if (fcnt == LAST) state <= WAIT;
        end
        WAIT: begin
          if (ccnt == FULL && done_seen) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_buf_ctrl.sv
// Bench for matmul_buf_ctrl: host-access vector table, directed multiply runs and random runs,
// checked against a row-level buffer model and a stub core that echoes A^B after a set latency.
module tb_matmul_buf_ctrl;
  localparam int DWIDTH = 16;
  localparam int SIZE   = 16;
  localparam int AWIDTH = 7;
  localparam int RW     = SIZE * DWIDTH;
  localparam int DEPTH  = 1 << AWIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_buf_ctrl_if #(.DWIDTH(DWIDTH), .SIZE(SIZE), .AWIDTH(AWIDTH)) bus ();
  matmul_buf_ctrl #(.DWIDTH(DWIDTH), .SIZE(SIZE), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit we_a;
    bit we_b;
    bit re_c;
    int addr;
    bit exp_err;
    bit exp_rvalid;
  } vec_t;

  logic [RW-1:0] ref_a [DEPTH];
  logic [RW-1:0] ref_b [DEPTH];
  logic [RW-1:0] ref_c [DEPTH];
  bit            c_known [DEPTH];
  int pass_cnt = 0;
  int check_cnt = 0;

  int stub_lat = 4;
  bit stub_early = 1'b0;
  bit stub_extra = 1'b0;
  int cyc = 0;
  int start_cyc = 0, rows_sent = 0, last_row_cyc = 0, done_cyc = 0;
  int done_cnt = 0, err_cnt = 0, run_done0 = 0, run_err0 = 0;
  bit extra_due = 1'b0;
  logic [RW-1:0] feed_a_q [$];
  logic [RW-1:0] feed_b_q [$];
  int            feed_cyc_q [$];
  logic [RW-1:0] echo_q [$];
  int            due_q [$];

  // Stub core plus event counters; runs on the falling edge, main sequence a little later.
  always @(negedge clk) begin
    cyc++;
    bus.core_c_valid = 1'b0;
    bus.core_done    = 1'b0;
    bus.core_c_data  = '0;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.host_err === 1'b1) err_cnt++;
    if (bus.core_start === 1'b1) begin
      start_cyc = cyc;
      rows_sent = 0;
      extra_due = 1'b0;
      feed_a_q.delete();
      feed_b_q.delete();
      feed_cyc_q.delete();
      echo_q.delete();
      due_q.delete();
    end
    if (bus.core_feed_valid === 1'b1) begin
      feed_a_q.push_back(bus.core_a_data);
      feed_b_q.push_back(bus.core_b_data);
      feed_cyc_q.push_back(cyc);
      echo_q.push_back(bus.core_a_data ^ bus.core_b_data);
      due_q.push_back(cyc + stub_lat);
    end
    if (extra_due) begin
      bus.core_c_valid = 1'b1;
      bus.core_c_data  = {RW{1'b1}};
      extra_due = 1'b0;
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      bus.core_c_data  = echo_q.pop_front();
      bus.core_c_valid = 1'b1;
      rows_sent++;
      last_row_cyc = cyc;
      if (stub_early ? (rows_sent == SIZE - 1) : (rows_sent == SIZE)) bus.core_done = 1'b1;
      if (rows_sent == SIZE && stub_extra) extra_due = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, " busy"}, bus.busy, 1'b0);
    check_output({tag, " done"}, bus.done, 1'b0);
    check_output({tag, " core_start"}, bus.core_start, 1'b0);
    check_output({tag, " feed_valid"}, bus.core_feed_valid, 1'b0);
    check_output({tag, " flags"}, {bus.host_rvalid, bus.host_err, bus.c_ovf}, 3'b000);
    check_output({tag, " host_rdata"}, bus.host_rdata, '0);
    check_output({tag, " core_a_data"}, bus.core_a_data, '0);
    check_output({tag, " core_b_data"}, bus.core_b_data, '0);
  endtask

  task automatic write_row(input bit to_b, input int addr, input logic [RW-1:0] d);
    bus.host_we_a  = !to_b;
    bus.host_we_b  = to_b;
    bus.host_addr  = AWIDTH'(addr);
    bus.host_wdata = d;
    if (to_b) ref_b[addr] = d;
    else ref_a[addr] = d;
    tick();
    bus.host_we_a = 1'b0;
    bus.host_we_b = 1'b0;
  endtask

  task automatic read_c(input int addr, input string tag);
    bus.host_re_c = 1'b1;
    bus.host_addr = AWIDTH'(addr);
    tick();
    bus.host_re_c = 1'b0;
    check_output($sformatf("%s rvalid[%0d]", tag, addr), bus.host_rvalid, 1'b1);
    if (c_known[addr]) check_output($sformatf("%s rdata[%0d]", tag, addr), bus.host_rdata, ref_c[addr]);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [RW-1:0] wd;
    wd = rand_row();
    bus.host_we_a  = v.we_a;
    bus.host_we_b  = v.we_b;
    bus.host_re_c  = v.re_c;
    bus.host_addr  = AWIDTH'(v.addr);
    bus.host_wdata = wd;
    if (v.we_a) ref_a[v.addr] = wd;
    else if (v.we_b) ref_b[v.addr] = wd;
    tick();
    bus.host_we_a = 1'b0;
    bus.host_we_b = 1'b0;
    bus.host_re_c = 1'b0;
    check_output($sformatf("vec%0d host_err", idx), bus.host_err, v.exp_err);
    check_output($sformatf("vec%0d host_rvalid", idx), bus.host_rvalid, v.exp_rvalid);
    if (v.exp_rvalid) check_output($sformatf("vec%0d host_rdata", idx), bus.host_rdata, ref_c[v.addr]);
  endtask

  task automatic start_mul(input int ab, input int bb, input int cb, input int lat,
                           input bit early, input bit extra, input string tag);
    stub_lat   = lat;
    stub_early = early;
    stub_extra = extra;
    run_err0   = err_cnt;
    run_done0  = done_cnt;
    bus.a_base = AWIDTH'(ab);
    bus.b_base = AWIDTH'(bb);
    bus.c_base = AWIDTH'(cb);
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    check_output({tag, " start_ack busy/core_start/c_ovf"}, {bus.busy, bus.core_start, bus.c_ovf}, 3'b110);
  endtask

  task automatic finish_mul(input int ab, input int bb, input int cb, input bit exp_ovf,
                            input int exp_err, input string tag);
    int guard = 0;
    while (bus.done !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    check_output({tag, " done_pulse"}, bus.done, 1'b1);
    check_output({tag, " done_after_last_row"}, done_cyc - last_row_cyc, 2);
    tick();
    check_output({tag, " idle_after_done"}, {bus.busy, bus.done}, 2'b00);
    check_output({tag, " c_ovf"}, bus.c_ovf, exp_ovf);
    check_output({tag, " feed_count"}, feed_a_q.size(), SIZE);
    for (int i = 0; i < SIZE && i < feed_a_q.size(); i++) begin
      check_output($sformatf("%s feed_a[%0d]", tag, i), feed_a_q[i], ref_a[(ab + i) % DEPTH]);
      check_output($sformatf("%s feed_b[%0d]", tag, i), feed_b_q[i], ref_b[(bb + i) % DEPTH]);
      check_output($sformatf("%s feed_cycle[%0d]", tag, i), feed_cyc_q[i], start_cyc + 1 + i);
    end
    for (int i = 0; i < SIZE; i++) begin
      ref_c[(cb + i) % DEPTH]   = ref_a[(ab + i) % DEPTH] ^ ref_b[(bb + i) % DEPTH];
      c_known[(cb + i) % DEPTH] = 1'b1;
    end
    for (int i = 0; i < SIZE; i++) read_c((cb + i) % DEPTH, tag);
    repeat (3) tick();
    check_output({tag, " done_count"}, done_cnt - run_done0, 1);
    check_output({tag, " host_err_count"}, err_cnt - run_err0, exp_err);
    check_output({tag, " still_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    vec_t vecs [7];
    logic [RW-1:0] wd;
    int e0, guard, ab, bb, cb;

    vecs[0] = vec_t'{1'b1, 1'b0, 1'b0,  6, 1'b0, 1'b0};
    vecs[1] = vec_t'{1'b0, 1'b1, 1'b0, 41, 1'b0, 1'b0};
    vecs[2] = vec_t'{1'b1, 1'b1, 1'b0, 42, 1'b1, 1'b0};
    vecs[3] = vec_t'{1'b0, 1'b1, 1'b1, 43, 1'b1, 1'b0};
    vecs[4] = vec_t'{1'b1, 1'b1, 1'b1, 44, 1'b1, 1'b0};
    vecs[5] = vec_t'{1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b1};
    vecs[6] = vec_t'{1'b0, 1'b0, 1'b0,  9, 1'b0, 1'b0};

    reset = 1'b1;
    bus.host_we_a = 1'b0;
    bus.host_we_b = 1'b0;
    bus.host_re_c = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    bus.start = 1'b0;
    bus.a_base = '0;
    bus.b_base = '0;
    bus.c_base = '0;
    for (int i = 0; i < DEPTH; i++) c_known[i] = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check_all_zero("post_reset");

    e0 = err_cnt;
    for (int r = 0; r < DEPTH; r++) write_row(1'b0, r, (r < 16) ? RW'(r * 3) : rand_row());
    for (int r = 0; r < DEPTH; r++) write_row(1'b1, r, rand_row());
    tick();
    check_output("preload host_err_count", err_cnt - e0, 0);

    start_mul(0, 0, 0, 4, 1'b0, 1'b0, "load");
    finish_mul(0, 0, 0, 1'b0, 0, "load");

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);
    tick();
    check_output("rdata_hold", bus.host_rdata, ref_c[2]);

    start_mul(5, 40, 100, 4, 1'b0, 1'b0, "feed");
    finish_mul(5, 40, 100, 1'b0, 0, "feed");

    start_mul(120, 3, 125, 4, 1'b0, 1'b0, "wrap");
    finish_mul(120, 3, 125, 1'b0, 0, "wrap");

    // Host write into A while feeding, then a second start while waiting on results.
    start_mul(0, 60, 20, 8, 1'b0, 1'b0, "busy");
    repeat (2) tick();
    wd = rand_row();
    bus.host_we_a  = 1'b1;
    bus.host_addr  = AWIDTH'(12);
    bus.host_wdata = wd;
    repeat (2) tick();
    bus.host_we_a = 1'b0;
    guard = 0;
    while (feed_a_q.size() < SIZE && guard < 100) begin
      tick();
      guard++;
    end
    check_output("busy feed_complete_before_restart", feed_a_q.size(), SIZE);
    bus.a_base = AWIDTH'(77);
    bus.c_base = AWIDTH'(90);
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    check_output("busy start_ignored", {bus.busy, bus.core_start}, 2'b10);
    finish_mul(0, 60, 20, 1'b0, 2, "busy");

    start_mul(20, 80, 112, 4, 1'b1, 1'b1, "ovf");
    finish_mul(20, 80, 112, 1'b1, 0, "ovf");
    read_c(0, "ovf_untouched");

    start_mul(10, 70, 30, 4, 1'b0, 1'b0, "rst");
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check_all_zero("mid_run_reset");
    for (int i = 0; i < SIZE; i++) c_known[(30 + i) % DEPTH] = 1'b0;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check_output("after_reset busy", bus.busy, 1'b0);
    start_mul(33, 90, 50, 3, 1'b0, 1'b0, "post_rst");
    finish_mul(33, 90, 50, 1'b0, 0, "post_rst");

    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 3; w++) write_row(w[0], $urandom_range(0, DEPTH - 1), rand_row());
      ab = $urandom_range(0, DEPTH - 1);
      bb = $urandom_range(0, DEPTH - 1);
      cb = $urandom_range(0, DEPTH - 1);
      start_mul(ab, bb, cb, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", n));
      finish_mul(ab, bb, cb, 1'b0, 0, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
